frac_lut6_cfg_loader: RTL and testbench

FRAC_LUT6_CFG_LOADER -- requirements
Module: frac_lut6_cfg_loader

---
 rtl/frac_lut6_cfg_pkg.sv | 21 ++
 rtl/frac_lut6_cfg_shifter.sv | 59 +++++
 rtl/frac_lut6_cfg_loader.sv | 134 +++++++++++++
 tb/tb_frac_lut6_cfg_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/frac_lut6_cfg_pkg.sv
// Shared constants for the fracturable LUT6 configuration loader: chain geometry,
// FSM encoding and the layout of the serial image.
package frac_lut6_cfg_pkg;

  localparam int CHAIN_LEN_DEF = 65;
  localparam int WORD_W_DEF    = 16;
  localparam int SRAM_BITS     = 64;
  // Mode bit is the MSB of the serial image, so it leaves first and ends at the tail flop
  localparam int MODE_POS      = SRAM_BITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [SRAM_BITS:0] chain_image(input logic mode,
                                                     input logic [SRAM_BITS-1:0] sram);
    return {mode, sram};
  endfunction

endpackage

// File: rtl/frac_lut6_cfg_shifter.sv
// Parallel-in/serial-out driver for the configuration chain; captures the bits
// returning on the tail into a staging register and commits them on request.
module frac_lut6_cfg_shifter
  import frac_lut6_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF
) (
  input  logic                 prog_clk,
  input  logic                 pReset,
  input  logic                 load,
  input  logic [CHAIN_LEN-1:0] load_data,
  input  logic                 shift,
  input  logic                 clr,
  input  logic                 commit,
  input  logic                 tail,
  output logic                 head,
  output logic [CHAIN_LEN-1:0] rb_data
);

  logic [CHAIN_LEN-1:0] sr_r;
  logic [CHAIN_LEN-1:0] cap_r;
  logic [CHAIN_LEN-1:0] rb_r;
  logic [CHAIN_LEN-1:0] cap_s;

  assign cap_s = {cap_r[CHAIN_LEN-2:0], tail};

  // Image shifts out MSB first with zero refill; tail samples stage until commit
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      sr_r  <= {CHAIN_LEN{1'b0}};
      cap_r <= {CHAIN_LEN{1'b0}};
      rb_r  <= {CHAIN_LEN{1'b0}};
    end else begin
      if (clr) begin
        sr_r <= {CHAIN_LEN{1'b0}};
      end else if (load) begin
        sr_r <= load_data;
      end else if (shift) begin
        sr_r <= {sr_r[CHAIN_LEN-2:0], 1'b0};
      end else begin
        sr_r <= sr_r;
      end
      if (shift) begin
        cap_r <= cap_s;
      end else begin
        cap_r <= cap_r;
      end
      if (commit) begin
        rb_r <= cap_s;
      end else begin
        rb_r <= rb_r;
      end
    end
  end

  assign head    = sr_r[CHAIN_LEN-1];
  assign rb_data = rb_r;

endmodule

// File: rtl/frac_lut6_cfg_loader.sv
// Loads a fracturable LUT6 configuration chain: collects truth-table words,
// shifts {mode, sram[63:0]} into the chain and reads back the previous contents.
module frac_lut6_cfg_loader
  import frac_lut6_cfg_pkg::*;
#(
  parameter int CHAIN_LEN = CHAIN_LEN_DEF,
  parameter int WORD_W    = WORD_W_DEF
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_start,
  input  logic              cfg_mode,
  input  logic              word_valid,
  input  logic [WORD_W-1:0] word_data,
  output logic              word_ready,
  input  logic              cfg_abort,
  output logic              ccff_head,
  output logic              ccff_en,
  input  logic              ccff_tail,
  output logic              cfg_busy,
  output logic              cfg_done,
  output logic [63:0]       rb_sram,
  output logic              rb_mode
);

  localparam int NWORDS = SRAM_BITS / WORD_W;
  localparam int WC_W   = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int SC_W   = $clog2(CHAIN_LEN);
  localparam int IDX_W  = $clog2(SRAM_BITS);
  localparam logic [WC_W-1:0] LAST_WORD  = WC_W'(NWORDS - 1);
  localparam logic [SC_W-1:0] LAST_SHIFT = SC_W'(CHAIN_LEN - 1);

  logic [1:0]           state_r, state_s;
  logic [WC_W-1:0]      word_cnt_r;
  logic [SC_W-1:0]      shift_cnt_r;
  logic                 mode_r;
  logic [SRAM_BITS-1:0] shadow_r, shadow_s;
  logic [IDX_W-1:0]     wbase_s;
  logic                 word_ready_r, ccff_en_r, busy_r, done_r;
  logic                 beat_s, load_s, commit_s, clr_s;
  logic [CHAIN_LEN-1:0] rb_data_s;

  assign beat_s  = word_valid && word_ready_r;
  assign wbase_s = IDX_W'(word_cnt_r) * IDX_W'(WORD_W);

  // Next-state decode and shadow write; abort outranks every other input
  always_comb begin
    state_s  = state_r;
    shadow_s = shadow_r;
    if (beat_s) begin
      shadow_s[wbase_s +: WORD_W] = word_data;
    end else begin
      shadow_s = shadow_r;
    end
    case (state_r)
      ST_IDLE: begin
        if (cfg_start) state_s = ST_FILL;
        else           state_s = ST_IDLE;
      end
      ST_FILL: begin
        if (cfg_abort)                            state_s = ST_IDLE;
        else if (beat_s && word_cnt_r == LAST_WORD) state_s = ST_SHIFT;
        else                                      state_s = ST_FILL;
      end
      ST_SHIFT: begin
        if (cfg_abort)                      state_s = ST_IDLE;
        else if (shift_cnt_r == LAST_SHIFT) state_s = ST_DONE;
        else                                state_s = ST_SHIFT;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  assign load_s   = (state_r == ST_FILL)  && (state_s == ST_SHIFT);
  assign commit_s = (state_r == ST_SHIFT) && (state_s == ST_DONE);
  assign clr_s    = (state_r == ST_SHIFT) && (state_s == ST_IDLE);

  // State, counters and outputs registered from the next state
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_r      <= ST_IDLE;
      word_cnt_r   <= {WC_W{1'b0}};
      shift_cnt_r  <= {SC_W{1'b0}};
      mode_r       <= 1'b0;
      shadow_r     <= {SRAM_BITS{1'b0}};
      word_ready_r <= 1'b0;
      ccff_en_r    <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      shadow_r     <= shadow_s;
      word_ready_r <= (state_s == ST_FILL);
      ccff_en_r    <= (state_s == ST_SHIFT);
      busy_r       <= (state_s != ST_IDLE);
      done_r       <= (state_s == ST_DONE);
      if (state_r == ST_IDLE && cfg_start) begin
        mode_r     <= cfg_mode;
        word_cnt_r <= {WC_W{1'b0}};
      end else if (beat_s) begin
        word_cnt_r <= word_cnt_r + 1'b1;
      end
      if (load_s) begin
        shift_cnt_r <= {SC_W{1'b0}};
      end else if (state_r == ST_SHIFT && state_s == ST_SHIFT) begin
        shift_cnt_r <= shift_cnt_r + 1'b1;
      end
    end
  end

  frac_lut6_cfg_shifter #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_shifter (
    .prog_clk  (prog_clk),
    .pReset    (pReset),
    .load      (load_s),
    .load_data (chain_image(mode_r, shadow_s)),
    .shift     (ccff_en_r),
    .clr       (clr_s),
    .commit    (commit_s),
    .tail      (ccff_tail),
    .head      (ccff_head),
    .rb_data   (rb_data_s)
  );

  assign word_ready = word_ready_r;
  assign ccff_en    = ccff_en_r;
  assign cfg_busy   = busy_r;
  assign cfg_done   = done_r;
  assign rb_sram    = rb_data_s[SRAM_BITS-1:0];
  assign rb_mode    = rb_data_s[MODE_POS];

endmodule

// File: tb/tb_frac_lut6_cfg_loader.sv
// Scoreboard bench: loads push the expected chain image and readback, a monitor
// checks them on every cfg_done against a 65-flop chain model.
module tb_frac_lut6_cfg_loader;

  logic        prog_clk = 1'b0;
  logic        pReset = 1'b0;
  logic        cfg_start = 1'b0;
  logic        cfg_mode = 1'b0;
  logic        word_valid = 1'b0;
  logic [15:0] word_data = 16'h0;
  logic        cfg_abort = 1'b0;
  logic        word_ready, ccff_head, ccff_en, cfg_busy, cfg_done, rb_mode;
  logic [63:0] rb_sram;
  logic        ccff_tail;

  // chain[0] is the head flop, chain[64] the tail flop
  logic [64:0] chain = 65'h0;
  assign ccff_tail = chain[64];

  always #5 prog_clk = ~prog_clk;

  always @(posedge prog_clk) begin
    if (ccff_en) chain <= {chain[63:0], ccff_head};
  end

  frac_lut6_cfg_loader #(.CHAIN_LEN(65), .WORD_W(16)) dut (
    .prog_clk(prog_clk), .pReset(pReset), .cfg_start(cfg_start), .cfg_mode(cfg_mode),
    .word_valid(word_valid), .word_data(word_data), .word_ready(word_ready),
    .cfg_abort(cfg_abort), .ccff_head(ccff_head), .ccff_en(ccff_en),
    .ccff_tail(ccff_tail), .cfg_busy(cfg_busy), .cfg_done(cfg_done),
    .rb_sram(rb_sram), .rb_mode(rb_mode)
  );

  typedef struct packed {
    logic [64:0] img;
    logic [64:0] rb;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  int          en_cnt = 0;
  int          beat_cnt = 0;
  int          done_cnt = 0;
  logic [64:0] model_c = 65'h0;   // what the chain holds, as {mode, sram}
  logic [64:0] model_rb = 65'h0;  // what readback should show

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // Chain contents after k bits of image s have been pushed in (MSB first)
  function automatic logic [64:0] shifted(input logic [64:0] c, input logic [64:0] s, input int k);
    return (c << k) | (s >> (65 - k));
  endfunction

  always @(negedge prog_clk) begin : monitor
    exp_t e;
    if (ccff_en) en_cnt++;
    if (word_valid && word_ready) beat_cnt++;
    if (cfg_done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got cfg_done=1 expected 0");
      end else begin
        e = exp_q.pop_front();
        chk("chain_image", chain, e.img);
        chk("readback", {rb_mode, rb_sram}, e.rb);
        chk("en_cycles", 65'(en_cnt), 65'd65);
        chk("beats", 65'(beat_cnt), 65'd4);
      end
      en_cnt = 0;
      beat_cnt = 0;
      done_cnt++;
    end
  end

  // stop_mode: 0 complete, 1 abort at SHIFT cycle stop_cyc, 2 reset at SHIFT cycle stop_cyc
  // gap_kind:  0 back-to-back words, 1 valid alternating 1-0-1-0, 2 random gaps
  task automatic do_load(input logic mode, input logic [63:0] words, input int gap_kind,
                         input bit mid_start, input int stop_mode, input int stop_cyc);
    logic [64:0] img;
    int got, guard, d0;
    bit gap;
    img = {mode, words};
    got = 0;
    guard = 0;
    en_cnt = 0;
    beat_cnt = 0;
    if (stop_mode == 0) begin
      exp_q.push_back('{img: img, rb: model_c});
      model_rb = model_c;
      model_c = img;
    end
    cfg_mode = mode;
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    cfg_mode = ~mode;
    chk("fill_ready", 65'(word_ready), 65'd1);
    while (got < 4 && guard < 64) begin
      guard++;
      if (gap_kind == 1) gap = (guard % 2 == 0);
      else if (gap_kind == 2) gap = ($urandom_range(0, 1) == 0);
      else gap = 1'b0;
      if (gap) begin
        word_valid = 1'b0;
        word_data = 16'($urandom);
        if (mid_start && guard == 4) cfg_start = 1'b1;
      end else begin
        word_valid = 1'b1;
        word_data = words[got*16 +: 16];
        got++;
      end
      tick();
      cfg_start = 1'b0;
    end
    word_valid = 1'b0;
    if (stop_mode == 0) begin
      d0 = done_cnt;
      guard = 0;
      while (done_cnt == d0 && guard < 200) begin
        tick();
        guard++;
      end
      if (done_cnt == d0) begin
        checks++;
        errors++;
        $display("FAIL done_timeout: got no cfg_done expected one within 200 cycles");
      end else begin
        chk("idle_after_done", 65'(cfg_busy), 65'd0);
      end
    end else if (stop_mode == 1) begin
      repeat (stop_cyc) tick();
      cfg_abort = 1'b1;
      tick();
      cfg_abort = 1'b0;
      chk("abort_en_low", 65'(ccff_en), 65'd0);
      chk("abort_busy", 65'(cfg_busy), 65'd0);
      chk("abort_en_cycles", 65'(en_cnt), 65'(stop_cyc + 1));
      model_c = shifted(model_c, img, stop_cyc + 1);
      repeat (4) tick();
      chk("abort_rb_kept", {rb_mode, rb_sram}, model_rb);
    end else begin
      repeat (stop_cyc) tick();
      pReset = 1'b0;
      #1;
      chk("rst_en", 65'(ccff_en), 65'd0);
      chk("rst_head", 65'(ccff_head), 65'd0);
      chk("rst_ready", 65'(word_ready), 65'd0);
      chk("rst_busy", 65'(cfg_busy), 65'd0);
      chk("rst_done", 65'(cfg_done), 65'd0);
      chk("rst_rb", {rb_mode, rb_sram}, 65'h0);
      chk("rst_en_cycles", 65'(en_cnt), 65'(stop_cyc));
      model_c = shifted(model_c, img, stop_cyc);
      model_rb = 65'h0;
      repeat (2) tick();
      pReset = 1'b1;
      tick();
    end
  endtask

  initial begin
    logic [63:0] w;
    // reset with a start request held: must not be honoured
    cfg_start = 1'b1;
    repeat (2) @(negedge prog_clk);
    chk("reset_en", 65'(ccff_en), 65'd0);
    chk("reset_head", 65'(ccff_head), 65'd0);
    chk("reset_ready", 65'(word_ready), 65'd0);
    chk("reset_busy", 65'(cfg_busy), 65'd0);
    chk("reset_done", 65'(cfg_done), 65'd0);
    chk("reset_rb", {rb_mode, rb_sram}, 65'h0);
    cfg_start = 1'b0;
    #2;
    pReset = 1'b1;
    tick();
    chk("idle_after_release", 65'(cfg_busy), 65'd0);

    do_load(1'b1, 64'h0001_FFFF_0F0F_A5A5, 0, 1'b0, 0, 0);
    chk("first_sram", 65'(chain[63:0]), 65'h0001_FFFF_0F0F_A5A5);
    chk("first_mode", 65'(chain[64]), 65'd1);

    do_load(1'b0, 64'h0, 0, 1'b0, 0, 0);
    chk("second_rb_sram", 65'(rb_sram), 65'h0001_FFFF_0F0F_A5A5);
    chk("second_rb_mode", 65'(rb_mode), 65'd1);
    chk("second_chain_zero", chain, 65'h0);

    w = {$urandom, $urandom};
    do_load(1'b1, w, 0, 1'b0, 1, 30);
    w = {$urandom, $urandom};
    do_load(1'b0, w, 2, 1'b0, 0, 0);

    do_load(1'b1, 64'h0001_FFFF_0F0F_A5A5, 1, 1'b1, 0, 0);
    chk("toggle_sram", 65'(chain[63:0]), 65'h0001_FFFF_0F0F_A5A5);

    w = {$urandom, $urandom};
    do_load(1'b0, w, 0, 1'b0, 2, 10);
    w = {$urandom, $urandom};
    do_load(1'b1, w, 0, 1'b0, 0, 0);

    for (int i = 0; i < 6; i++) begin
      w = {$urandom, $urandom};
      do_load(1'($urandom_range(0, 1)), w, 2, 1'b0, 0, 0);
    end

    repeat (4) tick();
    chk("queue_drained", 65'(exp_q.size()), 65'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
